// File: rtl/ssd_pkg.sv
// Shared types and the hex-to-7-segment decode for the keypad entry display.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package ssd_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    MODE_SHIFT  = 1'b0,
    MODE_CURSOR = 1'b1
  } entry_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } qual_state_e;

  localparam seg7_t SEG_BLANK = 7'h00;

  function automatic seg7_t hex_to_seg(input logic [3:0] hex);
    seg7_t s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_keypad_entry_if.sv
// Keypad-side inputs and display-side outputs of the keypad entry controller.
// master = decoder/board side, slave = controller.
interface ssd_keypad_entry_if #(
  parameter int NUM_DIGITS = 2
);
  import ssd_pkg::*;

  localparam int CW = $clog2(NUM_DIGITS);

  logic                  key_pressed;
  logic [3:0]            key_code;
  logic                  mode;
  logic                  clr;
  seg7_t                 seg;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  chip_sel;
  logic                  key_stb;
  logic [CW-1:0]         cursor;

  modport master (
    output key_pressed, key_code, mode, clr,
    input  seg, digit_en, chip_sel, key_stb, cursor
  );

  modport slave (
    input  key_pressed, key_code, mode, clr,
    output seg, digit_en, chip_sel, key_stb, cursor
  );

endinterface

// File: rtl/ssd_scan.sv
// Time-multiplexes the digit buffer onto one 7-segment bus; REFRESH_DIV cycles per digit.
// digit_en/seg/chip_sel share one register stage; SSD_BLANK_UNUSED_EN darkens unwritten digits.
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 125_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS-1:0][3:0]  digits,
  input  logic [NUM_DIGITS-1:0]       valid,
  output seg7_t                       seg,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        chip_sel
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

`ifdef SSD_BLANK_UNUSED_EN
  localparam seg7_t SEG_RST = SEG_BLANK;
`else
  localparam seg7_t SEG_RST = 7'h3F;
  logic unused_valid;
  assign unused_valid = ^valid;
`endif

  logic [DW-1:0] div;
  logic [IW-1:0] idx, idx_nxt;
  logic          term;
  seg7_t         seg_nxt;

  // All outputs derive from idx_nxt so enable and segments switch on the same edge.
  always_comb begin
    term    = (div == DW'(REFRESH_DIV - 1));
    idx_nxt = idx;
    if (term) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    seg_nxt = hex_to_seg(digits[idx_nxt]);
`ifdef SSD_BLANK_UNUSED_EN
    if (!valid[idx_nxt]) seg_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      idx      <= '0;
      digit_en <= NUM_DIGITS'(1);
      seg      <= SEG_RST;
      chip_sel <= 1'b0;
    end else begin
      div      <= term ? '0 : div + 1'b1;
      idx      <= idx_nxt;
      digit_en <= NUM_DIGITS'(1) << idx_nxt;
      seg      <= seg_nxt;
      chip_sel <= idx_nxt[0];
    end
  end

endmodule

// File: rtl/ssd_keypad_entry.sv
// Debounces keypad presses into an N-digit buffer (shift or cursor entry) and scans it out.
// key_stb fires STABLE_CYCLES cycles after press onset; SSD_BLANK_UNUSED_EN blanks unwritten digits.
module ssd_keypad_entry
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int REFRESH_DIV   = 125_000,
  parameter int STABLE_CYCLES = 1_250_000
) (
  input logic               clk,
  input logic               rst_n,
  ssd_keypad_entry_if.slave bus
);

  localparam int CW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  qual_state_e                state, state_nxt;
  logic [SW-1:0]              cnt, cnt_nxt;
  logic [3:0]                 code_q, code_nxt;
  logic                       armed, armed_nxt;
  logic                       accept, stable_done, key_stb_q;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      valid;
  logic [CW-1:0]              cursor;
  entry_mode_e                mode_q, cur_mode;

  assign cur_mode    = entry_mode_e'(bus.mode);
  assign stable_done = (cnt >= SW'(STABLE_CYCLES - 1));

  // armed stays low after reset until the key has been seen released long enough,
  // so a press still held across reset is never accepted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code_q;
    armed_nxt = armed;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!armed) begin
          if (bus.key_pressed) cnt_nxt = '0;
          else if (stable_done) begin
            armed_nxt = 1'b1;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + 1'b1;
        end else if (bus.key_pressed) begin
          state_nxt = PRESS_WAIT;
          code_nxt  = bus.key_code;
          cnt_nxt   = SW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!bus.key_pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (bus.key_code != code_q) begin
          code_nxt = bus.key_code;
          cnt_nxt  = SW'(1);
        end else if (stable_done) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      HELD: begin
        if (!bus.key_pressed) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = SW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (bus.key_pressed) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (stable_done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      code_q    <= '0;
      armed     <= 1'b0;
      key_stb_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      code_q    <= code_nxt;
      armed     <= armed_nxt;
      key_stb_q <= accept;
    end
  end

  // clr outranks a same-cycle accept; the strobe still fires from the qualifier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits <= '0;
      valid  <= '0;
      cursor <= '0;
      mode_q <= MODE_SHIFT;
    end else begin
      mode_q <= cur_mode;
      if (bus.clr) begin
        digits <= '0;
        valid  <= '0;
        cursor <= '0;
      end else begin
        if (accept) begin
          if (cur_mode == MODE_CURSOR) begin
            digits[cursor] <= code_q;
            valid[cursor]  <= 1'b1;
          end else begin
            digits <= {digits[NUM_DIGITS-2:0], code_q};
            valid  <= {valid[NUM_DIGITS-2:0], 1'b1};
          end
        end
        if (cur_mode != mode_q) cursor <= '0;
        else if (accept && cur_mode == MODE_CURSOR)
          cursor <= (cursor == CW'(NUM_DIGITS - 1)) ? '0 : cursor + 1'b1;
      end
    end
  end

  assign bus.key_stb = key_stb_q;
  assign bus.cursor  = cursor;

  ssd_scan #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits),
    .valid    (valid),
    .seg      (bus.seg),
    .digit_en (bus.digit_en),
    .chip_sel (bus.chip_sel)
  );

endmodule

// File: tb/tb_ssd_keypad_entry.sv
// Directed bench for ssd_keypad_entry with NUM_DIGITS=4, REFRESH_DIV=4, STABLE_CYCLES=3.
module tb_ssd_keypad_entry;
  import ssd_pkg::*;

`ifdef SSD_BLANK_UNUSED_EN
  localparam logic [6:0] IDLE_SEG = 7'h00;
`else
  localparam logic [6:0] IDLE_SEG = 7'h3F;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ssd_keypad_entry_if #(.NUM_DIGITS(4)) bus ();

  ssd_keypad_entry #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stb_cnt  = 0;
  int last_stb = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.key_stb === 1'b1) begin
      stb_cnt  <= stb_cnt + 1;
      last_stb <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel, input string tag);
    int s0, t0;
    s0              = stb_cnt;
    bus.key_code    = code;
    bus.key_pressed = 1'b1;
    t0              = cyc;
    tick(hold);
    bus.key_pressed = 1'b0;
    tick(rel);
    chk({tag, "_stb_count"}, 32'(stb_cnt - s0), 32'd1);
    chk({tag, "_stb_latency"}, 32'(last_stb - t0), 32'd3);
  endtask

  task automatic wait_digit(input int d, input logic [6:0] exp_seg, input string tag);
    int n = 0;
    while (bus.digit_en !== 4'(1 << d) && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, "_found"}, 32'(n < 20), 32'd1);
    chk({tag, "_seg"}, 32'(bus.seg), 32'(exp_seg));
  endtask

  initial begin
    int s0, t0;
    bus.key_pressed = 1'b0;
    bus.key_code    = 4'h0;
    bus.mode        = 1'b0;
    bus.clr         = 1'b0;
    rst_n           = 1'b0;
    tick(3);
    rst_n = 1'b1;

    chk("rst_digit_en", 32'(bus.digit_en), 32'h1);
    chk("rst_seg", 32'(bus.seg), 32'(IDLE_SEG));
    chk("rst_chip_sel", 32'(bus.chip_sel), 32'd0);
    chk("rst_key_stb", 32'(bus.key_stb), 32'd0);
    chk("rst_cursor", 32'(bus.cursor), 32'd0);
    chk("rst_digits", 32'(dut.digits), 32'h0);
    chk("rst_valid", 32'(dut.valid), 32'h0);

    // Free-running scan: each digit for 4 cycles.
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("scan_en_%0d", i), 32'(bus.digit_en), 32'(1 << ((i / 4) % 4)));
      chk($sformatf("scan_cs_%0d", i), 32'(bus.chip_sel), 32'((i / 4) % 2));
      chk($sformatf("scan_seg_%0d", i), 32'(bus.seg), 32'(IDLE_SEG));
      tick(1);
    end

    // Shift entry 1..5: oldest digit falls off.
    press(4'h1, 5, 5, "sh1");
    press(4'h2, 5, 5, "sh2");
    press(4'h3, 5, 5, "sh3");
    press(4'h4, 5, 5, "sh4");
    press(4'h5, 5, 5, "sh5");
    chk("sh_digits", 32'(dut.digits), 32'h2345);
    chk("sh_valid", 32'(dut.valid), 32'hF);
    wait_digit(0, 7'h6D, "sh_d0");
    wait_digit(3, 7'h5B, "sh_d3");

    // Bounce 1,0,1,1,1 on code 7.
    s0 = stb_cnt;
    bus.key_code    = 4'h7;
    bus.key_pressed = 1'b1;
    tick(1);
    bus.key_pressed = 1'b0;
    tick(1);
    bus.key_pressed = 1'b1;
    t0 = cyc;
    tick(4);
    bus.key_pressed = 1'b0;
    tick(5);
    chk("bounce_stb_count", 32'(stb_cnt - s0), 32'd1);
    chk("bounce_stb_latency", 32'(last_stb - t0), 32'd3);
    chk("bounce_digits", 32'(dut.digits), 32'h3457);

    // Code change 7->8 while waiting restarts the count.
    s0 = stb_cnt;
    bus.key_code    = 4'h7;
    bus.key_pressed = 1'b1;
    t0 = cyc;
    tick(1);
    bus.key_code = 4'h8;
    tick(4);
    bus.key_pressed = 1'b0;
    tick(5);
    chk("relatch_stb_count", 32'(stb_cnt - s0), 32'd1);
    chk("relatch_stb_latency", 32'(last_stb - t0), 32'd4);
    chk("relatch_digits", 32'(dut.digits), 32'h4578);

    // Cursor entry with wrap.
    bus.mode = 1'b1;
    tick(2);
    chk("cur_start", 32'(bus.cursor), 32'd0);
    press(4'hA, 5, 5, "curA");
    press(4'hB, 5, 5, "curB");
    press(4'hC, 5, 5, "curC");
    press(4'hD, 5, 5, "curD");
    chk("cur_digits_4", 32'(dut.digits), 32'hDCBA);
    chk("cur_wrap", 32'(bus.cursor), 32'd0);
    press(4'hE, 5, 5, "curE");
    chk("cur_digits_5", 32'(dut.digits), 32'hDCBE);
    chk("cur_after_e", 32'(bus.cursor), 32'd1);
    bus.mode = 1'b0;
    tick(2);
    chk("toggle_cursor", 32'(bus.cursor), 32'd0);
    chk("toggle_digits", 32'(dut.digits), 32'hDCBE);

    // clr coincident with accept of 9.
    bus.mode = 1'b1;
    tick(2);
    press(4'h1, 5, 5, "cl1");
    chk("cl_pre_cursor", 32'(bus.cursor), 32'd1);
    chk("cl_pre_digits", 32'(dut.digits), 32'hDCB1);
    s0 = stb_cnt;
    bus.key_code    = 4'h9;
    bus.key_pressed = 1'b1;
    tick(2);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("clr_key_stb", 32'(bus.key_stb), 32'd1);
    chk("clr_digits", 32'(dut.digits), 32'h0);
    chk("clr_valid", 32'(dut.valid), 32'h0);
    chk("clr_cursor", 32'(bus.cursor), 32'd0);
    tick(2);
    bus.key_pressed = 1'b0;
    tick(5);
    chk("clr_stb_count", 32'(stb_cnt - s0), 32'd1);
    wait_digit(2, IDLE_SEG, "clr_d2");

    // Reset during PRESS_WAIT with key still held.
    s0 = stb_cnt;
    bus.key_code    = 4'h6;
    bus.key_pressed = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("rmp_no_stb", 32'(stb_cnt - s0), 32'd0);
    bus.key_pressed = 1'b0;
    tick(3);
    bus.key_pressed = 1'b1;
    t0 = cyc;
    tick(3);
    chk("rmp_key_stb", 32'(bus.key_stb), 32'd1);
    bus.key_pressed = 1'b0;
    tick(5);
    chk("rmp_stb_count", 32'(stb_cnt - s0), 32'd1);
    chk("rmp_stb_latency", 32'(last_stb - t0), 32'd3);
    chk("rmp_digits", 32'(dut.digits), 32'h0006);
    chk("rmp_cursor", 32'(bus.cursor), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_keypad_entry.md
Name: ssd_keypad_entry

Overview:
- Parametrised multi-digit keypad-entry display controller.
- Takes the decoded keypad code and key-present flag from the keypad decoder, qualifies each press, and stores accepted digits in an N-digit buffer.
- Time-multiplexes the buffer onto one shared 7-segment bus with per-digit enables; chip_sel drives the dual-digit Pmod directly.
- Sits between keypad_decoder and the board pins, replacing the manual button-toggled chip select.

Parameters:
- NUM_DIGITS, 2, digits in buffer and scan (2..8).
- REFRESH_DIV, 125_000, clk cycles each digit is shown (1 ms at 125 MHz).
- STABLE_CYCLES, 1_250_000, cycles a key level and code must hold to count as a press or release (10 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- key_pressed  in  1  level from decoder: some key is down.
- key_code  in  4  hex value of the current key.
- mode  in  1  0 = shift entry, 1 = cursor entry.
- clr  in  1  single-cycle pulse; clears the buffer.
- seg  out  7  {g,f,e,d,c,b,a}, active-high.
- digit_en  out  NUM_DIGITS  one-hot; lit digit, bit 0 = rightmost.
- chip_sel  out  1  scan index bit 0 (0 = right digit).
- key_stb  out  1  one-cycle pulse per accepted key.
- cursor  out  $clog2(NUM_DIGITS)  next write position in cursor mode.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - buffer all 0, valid bits all 0, cursor 0.
  - scan index 0, digit_en = 1, seg = 7'h3F (digit 0), key_stb 0.
  - qualifier state IDLE, counters 0.
  - Reset mid-press discards the press; the qualifier then needs a full release before it can accept.
- Qualifier FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: key_pressed=1 -> PRESS_WAIT; latch key_code; count=1.
  - PRESS_WAIT:
    - key_pressed=0 -> IDLE.
    - key_code differs from latched value -> relatch, count=1.
    - count reaches STABLE_CYCLES -> HELD; key_stb=1 on that cycle.
  - HELD: key_pressed=0 -> RELEASE_WAIT, count=1. No further accepts while held.
  - RELEASE_WAIT:
    - key_pressed=1 -> HELD.
    - count reaches STABLE_CYCLES -> IDLE.
- Latency: key_stb fires STABLE_CYCLES cycles after the first cycle key_pressed=1 with a stable code. The buffer updates on the same edge that key_stb is registered high.
- Shift mode (mode=0): buf <= {buf[N-2:0], code}; valid <= {valid[N-2:0], 1}. The oldest digit is discarded at overflow.
- Cursor mode (mode=1):
  - buf[cursor] <= code; valid[cursor] <= 1.
  - cursor <= cursor+1, wrapping NUM_DIGITS-1 -> 0.
- Any change of mode (registered edge detect) sets cursor to 0. The buffer is kept.
- clr: buffer, valid and cursor go to 0 on the next edge.
  - clr and acceptance in the same cycle: clr wins, the key is dropped, and key_stb still pulses.
- Scan:
  - divider counts 0..REFRESH_DIV-1; at terminal count, scan index increments, wrapping NUM_DIGITS-1 -> 0.
  - digit_en, seg and chip_sel are registered and change together, with no cross-digit glitch.
- Seg encoding: 0-F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.

Optional Feature:
- Macro: SSD_BLANK_UNUSED_EN.
- Defined: a digit with valid=0 drives seg=7'h00 while scanned. After reset or clr the display is dark until entry.
- Undefined: valid bits are still tracked, but unwritten digits show "0" (7'h3F).

Decomposition:
- Package ssd_pkg:
  - seg7_t typedef (logic [6:0]).
  - entry_mode_e enum {MODE_SHIFT, MODE_CURSOR}.
  - qual_state_e enum for the FSM states.
  - function hex_to_seg(logic [3:0]) returning seg7_t.
- One sub-module, ssd_scan: divider, scan index, one-hot digit_en, registered seg mux. Parameters NUM_DIGITS and REFRESH_DIV. Inputs: buffer, valid.
- The qualifier FSM and buffer stay in ssd_keypad_entry.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, STABLE_CYCLES=3):
- Reset then free-run: digit_en cycles 0001,0010,0100,1000,0001 every 4 cycles; chip_sel toggles every 4 cycles; seg=3F throughout, or 00 with SSD_BLANK_UNUSED_EN.
- Shift mode, press 1,2,3,4,5, each held 5 cycles and released 5 cycles: five key_stb pulses, each 3 cycles after press onset; final buf = {2,3,4,5}, and digit 0 scans seg=6D.
- Bounce: key_pressed 1,0,1,1,1 with code 7: exactly one key_stb, on the 3rd cycle of the stable run. Code changing 7->8 mid-wait restarts the count, and 8 is accepted.
- Cursor mode, press A,B,C,D,E: buf[0..3] = A,B,C,D, then buf[0] = E, cursor = 1. Toggle mode: cursor = 0 and buf unchanged.
- clr asserted on the same cycle as key_stb for code 9: buffer is all 0, no 9 stored, cursor = 0.
- rst_n low during PRESS_WAIT, key still held after release of reset: no key_stb until release for 3 cycles followed by a new 3-cycle press.
